vga_scan_gen: RTL and testbench
===============================

Name: vga_scan_gen

Overview:
- VGA raster initiator: generates 640x480@60 Hz timing.
- Issues the pixel coordinate to be fetched (next_x/next_y) ahead of the beam, toward the zoom CPU.
- Accepts the fetched pixel FETCH_LAT pixel ticks later and drives hsync/vsync/blank_n/RGB with matching delay.
- Sits between the zoom CPU plus frame memory and the DAC pins; it is the requester for which the CPU is the responder.

Parameters:
- CLK_DIV, 2, system clocks per pixel tick (2 gives 50 MHz to 25 MHz); legal 1..8.
- FETCH_LAT, 3, pixel ticks from next_x/next_y issue to pixel_in/pixel_valid being valid; legal 1..15.
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixel ticks; total 800.
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines; total 525.

Ports:
- clk_in  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- next_x  out  10  fetch column, 0..639; 0 outside visible area.
- next_y  out  10  fetch row, 0..479; 0 outside visible area.
- coord_valid  out  1  next_x/next_y is inside the visible area this tick.
- pix_tick  out  1  one-cycle pixel-clock enable, shared with downstream fetch pipeline.
- pixel_in  in  8  grayscale pixel returned by the memory path.
- pixel_valid  in  1  pixel_in is inside the image; 0 forces black.
- hsync  out  1  horizontal sync, active-low.
- vsync  out  1  vertical sync, active-low.
- blank_n  out  1  1 = visible pixel being displayed.
- vga_r, vga_g, vga_b  out  8 each  display colour.
- frame_start  out  1  one-cycle pulse on the pix_tick where fetch position is (0,0).

Behaviour:
- All registers are updated on the rising edge of clk_in.
- Reset (reset==0 at an edge):
  - div counter, h_cnt and v_cnt go to 0.
  - Delay pipeline is cleared to the blank/inactive state.
  - hsync=1, vsync=1, blank_n=0, rgb=0, frame_start=0, pix_tick=0, coord_valid=0, next_x=next_y=0.
- Reset mid-frame aborts the line immediately; there is no completion of the current frame.
- Divider:
  - Counts 0..CLK_DIV-1; pix_tick=1 in the cycle where the count equals CLK_DIV-1.
  - With CLK_DIV=1, pix_tick stays 1 continuously after reset.
  - First pix_tick is in cycle CLK_DIV after reset release.
- Counters advance only on pix_tick:
  - h_cnt goes 0..799, wrapping to 0.
  - On each h wrap, v_cnt goes 0..524, wrapping to 0.
  - Simultaneous h and v wrap returns the position to (0,0).
- Fetch side (registered, 1 cycle after the counter update):
  - coord_valid = (h_cnt<640)&&(v_cnt<480).
  - next_x/next_y = h_cnt/v_cnt when coord_valid, else 0.
  - frame_start = pix_tick && h_cnt==0 && v_cnt==0.
- Display side:
  - vis, hs_raw and vs_raw are derived from h_cnt/v_cnt: hs_raw low for h in [656,751], vs_raw low for v in [490,491].
  - These are pushed through a FETCH_LAT-deep shift register advancing only on pix_tick.
  - hsync, vsync and blank_n are the delayed values, so they are aligned with pixel_in.
- Colour:
  - On pix_tick, rgb = (delayed vis && pixel_valid) ? {pixel_in,pixel_in,pixel_in} : 0.
  - Between ticks, outputs hold.
- No back-pressure: the responder must return data exactly FETCH_LAT ticks after issue. pixel_in is ignored outside the delayed visible window.
- Arithmetic: counter widths are 10 bits; comparisons are unsigned against parameter-derived constants. No overflow is possible for legal parameters.

Decomposition:
- Shared package vga_pkg:
  - Timing constants: H_TOTAL=800, V_TOTAL=525, sync start/end values.
  - COORD_W=10, PIX_W=8.
  - Struct/bundle for {vis, hs, vs} used by the delay line.
- One sub-module, vga_delay_line:
  - Parameterised depth and width shift register with enable and synchronous active-low clear.
  - Instantiated once for the {vis, hs, vs} bundle.

Test Plan:
- Reset release, CLK_DIV=2:
  - First pix_tick at cycle 2.
  - frame_start pulses; next_x=0, next_y=0, coord_valid=1 one cycle later.
- Line timing, CLK_DIV=2:
  - hsync period is 1600 clk; hsync low for exactly 192 clk.
  - blank_n high for 1280 clk per visible line.
- Frame timing:
  - vsync period is 840000 clk; vsync low for 3200 clk.
  - frame_start once per 840000 clk.
  - coord_valid true for 307200 ticks per frame.
- Latency alignment, FETCH_LAT=3:
  - Bench responder returns pixel_in = next_x[7:0] with pixel_valid=1, 3 ticks after each issue.
  - At every blank_n=1 tick, vga_r == displayed column[7:0]; first visible pixel is 0x00 and column 255 is 0xFF.
- pixel_valid=0 for x>=320:
  - rgb=0 on the right half of each visible line.
  - blank_n and syncs are unchanged.
- Reset asserted mid-line at h=400, v=100, held 5 clk:
  - During reset: hsync=1, vsync=1, blank_n=0, rgb=0.
  - After release: sequence restarts at (0,0) with frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA scan generator.
package vga_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned PIX_W   = 8;

  // Default 640x480@60 timing: horizontal in pixel ticks, vertical in lines.
  localparam int unsigned DEF_H_VIS  = 640;
  localparam int unsigned DEF_H_FP   = 16;
  localparam int unsigned DEF_H_SYNC = 96;
  localparam int unsigned DEF_H_BP   = 48;
  localparam int unsigned DEF_V_VIS  = 480;
  localparam int unsigned DEF_V_FP   = 10;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP   = 33;

  localparam int unsigned H_TOTAL  = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 800
  localparam int unsigned V_TOTAL  = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 525
  localparam int unsigned HS_START = DEF_H_VIS + DEF_H_FP;                         // 656
  localparam int unsigned HS_END   = HS_START + DEF_H_SYNC - 1;                    // 751
  localparam int unsigned VS_START = DEF_V_VIS + DEF_V_FP;                         // 490
  localparam int unsigned VS_END   = VS_START + DEF_V_SYNC - 1;                    // 491

  // Raster control bundle carried alongside the fetch latency; syncs are active-low.
  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } scan_ctl_t;

  // Blanked, syncs inactive.
  localparam scan_ctl_t CTL_IDLE = '{vis: 1'b0, hs: 1'b1, vs: 1'b1};

  // Inclusive unsigned window test used for the sync pulses.
  function automatic logic in_window(input logic [COORD_W-1:0] pos,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with synchronous active-low clear to a fixed value.
module vga_delay_line #(
  parameter int unsigned       WIDTH   = 3,
  parameter int unsigned       DEPTH   = 3,
  parameter logic [WIDTH-1:0]  CLR_VAL = '0
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one stage per enable; clear forces every stage to the idle value.
  // NOTE: this storage is cleared on reset on purpose -- a stale stage would
  // otherwise be displayed as a visible pixel or a spurious sync after reset.
  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= CLR_VAL;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster initiator: issues fetch coordinates ahead of the beam and drives
// sync/blank/colour aligned with the pixel returned FETCH_LAT ticks later.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned FETCH_LAT = 3,
  parameter int unsigned H_VIS     = DEF_H_VIS,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_VIS     = DEF_V_VIS,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP
) (
  input  logic               clk_in,
  input  logic               reset,
  output logic [COORD_W-1:0] next_x,
  output logic [COORD_W-1:0] next_y,
  output logic               coord_valid,
  output logic               pix_tick,
  input  logic [PIX_W-1:0]   pixel_in,
  input  logic               pixel_valid,
  output logic               hsync,
  output logic               vsync,
  output logic               blank_n,
  output logic [PIX_W-1:0]   vga_r,
  output logic [PIX_W-1:0]   vga_g,
  output logic [PIX_W-1:0]   vga_b,
  output logic               frame_start
);

  localparam int unsigned              DIV_W    = 3;
  localparam logic [DIV_W-1:0]         DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0]       H_VIS_C  = COORD_W'(H_VIS);
  localparam logic [COORD_W-1:0]       V_VIS_C  = COORD_W'(V_VIS);
  localparam logic [COORD_W-1:0]       H_LAST   = COORD_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [COORD_W-1:0]       V_LAST   = COORD_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [COORD_W-1:0]       HS_BEG   = COORD_W'(H_VIS + H_FP);
  localparam logic [COORD_W-1:0]       HS_LAST  = COORD_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0]       VS_BEG   = COORD_W'(V_VIS + V_FP);
  localparam logic [COORD_W-1:0]       VS_LAST  = COORD_W'(V_VIS + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick_q, tick_d;
  logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
  logic               cv_q, cv_d, fs_q, fs_d;
  logic [COORD_W-1:0] nx_q, nx_d, ny_q, ny_d;
  logic               hs_q, hs_d, vs_q, vs_d, bl_q, bl_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  scan_ctl_t          ctl_now, ctl_dly;

  // Pixel-tick divider and raster position; the tick is registered so it is low in reset.
  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    div_d  = div_q + 1'b1;
    tick_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d  = '0;
      tick_d = 1'b1;
    end
    h_d = h_q;
    v_d = v_q;
    if (tick_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Decode the current position into the fetch request and the raster control bundle.
  always_comb begin
    ctl_now.vis = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    ctl_now.hs  = !in_window(h_q, HS_BEG, HS_LAST);
    ctl_now.vs  = !in_window(v_q, VS_BEG, VS_LAST);
    cv_d = cv_q;
    nx_d = nx_q;
    ny_d = ny_q;
    fs_d = tick_q && (h_q == '0) && (v_q == '0);
    if (tick_q) begin
      cv_d = ctl_now.vis;
      nx_d = ctl_now.vis ? h_q : '0;
      ny_d = ctl_now.vis ? v_q : '0;
    end
  end

  // Display outputs take the delayed bundle and the returned pixel on the same tick.
  always_comb begin
    hs_d  = hs_q;
    vs_d  = vs_q;
    bl_d  = bl_q;
    pix_d = pix_q;
    if (tick_q) begin
      hs_d  = ctl_dly.hs;
      vs_d  = ctl_dly.vs;
      bl_d  = ctl_dly.vis;
      pix_d = (ctl_dly.vis && pixel_valid) ? pixel_in : '0;
    end
  end

  // State registers with synchronous active-low reset; reset aborts the frame at once.
  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      h_q    <= '0;
      v_q    <= '0;
      cv_q   <= 1'b0;
      nx_q   <= '0;
      ny_q   <= '0;
      fs_q   <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      bl_q   <= 1'b0;
      pix_q  <= '0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      h_q    <= h_d;
      v_q    <= v_d;
      cv_q   <= cv_d;
      nx_q   <= nx_d;
      ny_q   <= ny_d;
      fs_q   <= fs_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      bl_q   <= bl_d;
      pix_q  <= pix_d;
    end
  end

  vga_delay_line #(
    .WIDTH   ($bits(scan_ctl_t)),
    .DEPTH   (FETCH_LAT),
    .CLR_VAL (CTL_IDLE)
  ) u_ctl_dly (
    .clk_i   (clk_in),
    .clr_n_i (reset),
    .en_i    (tick_q),
    .d_i     (ctl_now),
    .q_o     (ctl_dly)
  );

  assign pix_tick    = tick_q;
  assign coord_valid = cv_q;
  assign next_x      = nx_q;
  assign next_y      = ny_q;
  assign frame_start = fs_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign blank_n     = bl_q;
  assign vga_r       = pix_q;
  assign vga_g       = pix_q;
  assign vga_b       = pix_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench: a full-size instance for reset, line timing, latency and
// mid-line reset, plus a shrunken-raster instance (CLK_DIV=1, FETCH_LAT=1)
// whose whole frame fits in a few hundred cycles.
module tb_vga_scan_gen;

  logic       clk_in;
  int         n_checks = 0;
  int         n_errors = 0;

  // Full-size instance
  logic       rst_n;
  logic [9:0] next_x, next_y;
  logic       coord_valid, pix_tick, hsync, vsync, blank_n, frame_start;
  logic [7:0] pixel_in, vga_r, vga_g, vga_b;
  logic       pixel_valid;

  // Small-raster instance: 8/2/3/3 by 6/2/1/2 -> 16 ticks per line, 11 lines.
  logic       s_rst_n;
  logic [9:0] s_next_x, s_next_y;
  logic       s_coord_valid, s_pix_tick, s_hsync, s_vsync, s_blank_n, s_frame_start;
  logic [7:0] s_pixel_in, s_vga_r, s_vga_g, s_vga_b;
  logic       s_pixel_valid;

  vga_scan_gen #(.CLK_DIV(2), .FETCH_LAT(3)) dut (
    .clk_in(clk_in), .reset(rst_n), .next_x(next_x), .next_y(next_y),
    .coord_valid(coord_valid), .pix_tick(pix_tick), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
  );

  vga_scan_gen #(
    .CLK_DIV(1), .FETCH_LAT(1),
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(2), .V_SYNC(1), .V_BP(2)
  ) dut_small (
    .clk_in(clk_in), .reset(s_rst_n), .next_x(s_next_x), .next_y(s_next_y),
    .coord_valid(s_coord_valid), .pix_tick(s_pix_tick), .pixel_in(s_pixel_in),
    .pixel_valid(s_pixel_valid), .hsync(s_hsync), .vsync(s_vsync), .blank_n(s_blank_n),
    .vga_r(s_vga_r), .vga_g(s_vga_g), .vga_b(s_vga_b), .frame_start(s_frame_start)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Controls written only by the main sequence.
  logic mon_en    = 1'b0;
  logic half_mode = 1'b0;
  int   epoch     = 0;

  // Full-size responder: returns {next_x[7:0], valid} three ticks after issue.
  logic [7:0] hist0_x = '0, hist1_x = '0;
  logic       hist0_v = 1'b1, hist1_v = 1'b1;
  initial begin
    pixel_in    = '0;
    pixel_valid = 1'b1;
    forever begin
      @(negedge clk_in);
      if (pix_tick) begin
        pixel_in    = hist1_x;
        pixel_valid = hist1_v;
        hist1_x     = hist0_x;
        hist1_v     = hist0_v;
        hist0_x     = next_x[7:0];
        hist0_v     = half_mode ? (next_x < 10'd320) : 1'b1;
      end
    end
  end

  // Full-size monitor: clock-accurate sync/blank widths and per-pixel colour.
  int         cyc = 0, seen_epoch = 0, col = 0;
  int         hs_fall = -1, hs_period = 0, hs_low = 0, bl_rise = -1, bl_width = 0;
  int         pix_err = 0, line_len = 0;
  logic [7:0] first_pix = 8'hAA, pix255 = 8'h00, pix319 = 8'h00, pix320 = 8'hEE, exp_pix;
  logic       hs_prev = 1'b1, bl_prev = 1'b0;
  initial forever begin
    @(negedge clk_in);
    cyc++;
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      hs_fall = -1; hs_period = 0; hs_low = 0; bl_rise = -1; bl_width = 0;
      pix_err = 0; line_len = 0; col = 0;
      first_pix = 8'hAA; pix255 = 8'h00; pix319 = 8'h00; pix320 = 8'hEE;
    end else if (mon_en) begin
      if (hs_prev && !hsync) begin
        if (hs_fall >= 0) hs_period = cyc - hs_fall;
        hs_fall = cyc;
      end
      if (!hs_prev && hsync && hs_fall >= 0) hs_low = cyc - hs_fall;
      if (!bl_prev && blank_n) bl_rise = cyc;
      if (bl_prev && !blank_n && bl_rise >= 0) bl_width = cyc - bl_rise;
      if (pix_tick) begin
        if (blank_n) begin
          exp_pix = (half_mode && col >= 320) ? 8'h00 : col[7:0];
          if (vga_r !== exp_pix || vga_g !== exp_pix || vga_b !== exp_pix) pix_err++;
          if (col == 0)   first_pix = vga_r;
          if (col == 255) pix255    = vga_r;
          if (col == 319) pix319    = vga_r;
          if (col == 320) pix320    = vga_r;
          col++;
        end else begin
          if (col != 0) line_len = col;
          col = 0;
        end
      end
    end
    hs_prev = hsync;
    bl_prev = blank_n;
  end

  // Small-raster responder and monitor: with FETCH_LAT=1 the pixel is next_x itself.
  logic s_run = 1'b0;
  int   s_cyc = 0, s_col = 0, s_line_len = 0, s_pix_err = 0, s_tick_gap = 0;
  int   s_vs_fall = -1, s_vs_period = 0, s_vs_low = 0;
  int   s_hs_fall = -1, s_hs_period = 0, s_hs_low = 0;
  int   s_fs_last = -1, s_fs_period = 0, s_fs_count = 0, s_cv_cnt = 0, s_cv_frame = 0;
  logic s_vs_prev = 1'b1, s_hs_prev = 1'b1;
  initial begin
    s_pixel_in    = '0;
    s_pixel_valid = 1'b1;
    forever begin
      @(negedge clk_in);
      s_cyc++;
      if (s_run) begin
        if (!s_pix_tick) s_tick_gap++;
        if (s_vs_prev && !s_vsync) begin
          if (s_vs_fall >= 0) s_vs_period = s_cyc - s_vs_fall;
          s_vs_fall = s_cyc;
        end
        if (!s_vs_prev && s_vsync && s_vs_fall >= 0) s_vs_low = s_cyc - s_vs_fall;
        if (s_hs_prev && !s_hsync) begin
          if (s_hs_fall >= 0) s_hs_period = s_cyc - s_hs_fall;
          s_hs_fall = s_cyc;
        end
        if (!s_hs_prev && s_hsync && s_hs_fall >= 0) s_hs_low = s_cyc - s_hs_fall;
        if (s_frame_start) begin
          if (s_fs_last >= 0) begin
            s_fs_period = s_cyc - s_fs_last;
            s_cv_frame  = s_cv_cnt;
          end
          s_fs_last = s_cyc;
          s_fs_count++;
          s_cv_cnt = 0;
        end
        if (s_coord_valid) s_cv_cnt++;
        if (s_blank_n) begin
          if (s_vga_r !== s_col[7:0]) s_pix_err++;
          s_col++;
        end else begin
          if (s_col != 0) s_line_len = s_col;
          s_col = 0;
        end
      end
      s_vs_prev  = s_vsync;
      s_hs_prev  = s_hsync;
      s_pixel_in = s_next_x[7:0];
    end
  end

  // Cycle-by-cycle start-up after reset release (called right after rst_n rises).
  task automatic check_restart();
    @(negedge clk_in);
    check("c1_tick", pix_tick, 0);
    @(negedge clk_in);
    check("c2_tick", pix_tick, 1);
    check("c2_fs", frame_start, 0);
    check("c2_cv", coord_valid, 0);
    @(negedge clk_in);
    check("c3_fs", frame_start, 1);
    check("c3_cv", coord_valid, 1);
    check("c3_x", next_x, 0);
    check("c3_y", next_y, 0);
    check("c3_tick", pix_tick, 0);
    @(negedge clk_in);
    check("c4_fs", frame_start, 0);
    check("c4_tick", pix_tick, 1);
    @(negedge clk_in);
    check("c5_x", next_x, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hsync"}, hsync, 1);
    check({tag, "_vsync"}, vsync, 1);
    check({tag, "_blank"}, blank_n, 0);
    check({tag, "_rgb"}, {8'h00, vga_r, vga_g, vga_b}, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic ok;
  initial begin
    rst_n   = 1'b0;
    s_rst_n = 1'b0;

    // Small raster: pix_tick low in reset, then high every cycle from cycle 1.
    repeat (3) @(negedge clk_in);
    check("s_rst_tick", s_pix_tick, 0);
    s_rst_n = 1'b1;
    @(negedge clk_in);
    check("s_first_tick", s_pix_tick, 1);
    s_run = 1'b1;

    // Full-size reset state.
    repeat (3) @(negedge clk_in);
    check_reset_outputs("rst");
    check("rst_tick", pix_tick, 0);
    check("rst_cv", coord_valid, 0);
    check("rst_xy", {next_x, next_y}, 0);
    check("rst_fs", frame_start, 0);

    rst_n = 1'b1;
    check_restart();

    // Line timing and latency alignment over three lines.
    epoch++;
    mon_en = 1'b1;
    repeat (5000) @(negedge clk_in);
    check("hs_period", hs_period, 1600);
    check("hs_low", hs_low, 192);
    check("blank_width", bl_width, 1280);
    check("line_len", line_len, 640);
    check("first_pix", first_pix, 8'h00);
    check("pix_255", pix255, 8'hFF);
    check("pix_err", pix_err, 0);
    check("vsync_idle", vsync, 1);

    // Right half marked invalid; switch during horizontal blanking.
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in);
      if (blank_n) begin ok = 1'b1; break; end
    end
    check("wait_vis", ok, 1);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in);
      if (!blank_n) begin ok = 1'b1; break; end
    end
    check("wait_blank", ok, 1);
    half_mode = 1'b1;
    epoch++;
    repeat (3400) @(negedge clk_in);
    check("half_pix_err", pix_err, 0);
    check("half_pix_319", pix319, 8'h3F);
    check("half_pix_320", pix320, 8'h00);
    check("half_blank_width", bl_width, 1280);
    check("half_hs_period", hs_period, 1600);
    check("half_hs_low", hs_low, 192);

    // Reset in the middle of a visible line at column 400.
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in);
      if (coord_valid && next_x == 10'd400) begin ok = 1'b1; break; end
    end
    check("wait_x400", ok, 1);
    check("pre_rst_blank", blank_n, 1);
    mon_en    = 1'b0;
    half_mode = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk_in);
    check_reset_outputs("mid_rst1");
    check("mid_rst1_cv", coord_valid, 0);
    repeat (4) @(negedge clk_in);
    check_reset_outputs("mid_rst5");
    epoch++;
    rst_n = 1'b1;
    check_restart();
    mon_en = 1'b1;
    repeat (1700) @(negedge clk_in);
    check("post_rst_line_len", line_len, 640);
    check("post_rst_pix_err", pix_err, 0);

    // Small-raster frame measurements accumulated in the background.
    check("s_vs_period", s_vs_period, 176);
    check("s_vs_low", s_vs_low, 16);
    check("s_hs_period", s_hs_period, 16);
    check("s_hs_low", s_hs_low, 3);
    check("s_fs_period", s_fs_period, 176);
    check("s_fs_seen", s_fs_count > 10, 1);
    check("s_cv_per_frame", s_cv_frame, 48);
    check("s_line_len", s_line_len, 8);
    check("s_pix_err", s_pix_err, 0);
    check("s_tick_gap", s_tick_gap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
